mc14500_icu: RTL and testbench

Sequencer and 1-bit logic unit for the MC14500B-style processor, sitting directly upstream of the IO block. It fetches 4-bit-opcode instructions from program memory and drives the IO block's `address`, `data_in` and `write` inputs. It reads back the IO block's `data_out` and maintains the result register (RR), input and output enables (IEN, OEN) and the skip flag. It also emits the JMP, RTN, FLAG O and FLAG F strobes.

---
 rtl/mc14500_pkg.sv | 34 +++
 rtl/mc14500_lu.sv | 28 ++
 rtl/mc14500_icu.sv | 134 +++++++++++++
 tb/tb_mc14500_icu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc14500_pkg.sv
// Shared types for the MC14500B-style sequencer and its 1-bit logic unit.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mc14500_pkg;

    // Opcode field width; the operand address occupies the bits below it
    localparam int OPC_WIDTH = 4;

    typedef enum logic [OPC_WIDTH-1:0] {
        OP_NOPO = 4'h0,
        OP_LD   = 4'h1,
        OP_LDC  = 4'h2,
        OP_AND  = 4'h3,
        OP_ANDC = 4'h4,
        OP_OR   = 4'h5,
        OP_ORC  = 4'h6,
        OP_XNOR = 4'h7,
        OP_STO  = 4'h8,
        OP_STOC = 4'h9,
        OP_IEN  = 4'hA,
        OP_OEN  = 4'hB,
        OP_JMP  = 4'hC,
        OP_RTN  = 4'hD,
        OP_SKZ  = 4'hE,
        OP_NOPF = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/mc14500_lu.sv
// 1-bit logic unit: computes the next result register value from opcode, RR and masked data.
// Latency: purely combinational.
// Backpressure: none; opcodes that do not touch RR pass it through unchanged.
module mc14500_lu
    import mc14500_pkg::*;
(
    input  logic [OPC_WIDTH-1:0] op,
    input  logic                 rr,
    input  logic                 d,
    output logic                 rr_next
);

    // Select the new RR for logic/load opcodes, hold it for everything else
    always_comb begin
        rr_next = rr;
        case (opcode_t'(op))
            OP_LD:   rr_next = d;
            OP_LDC:  rr_next = ~d;
            OP_AND:  rr_next = rr & d;
            OP_ANDC: rr_next = rr & ~d;
            OP_OR:   rr_next = rr | d;
            OP_ORC:  rr_next = rr | ~d;
            OP_XNOR: rr_next = ~(rr ^ d);
            default: rr_next = rr;
        endcase
    end

endmodule

// File: rtl/mc14500_icu.sv
// MC14500B-style sequencer: fetches instructions, drives the IO block, keeps RR/IEN/OEN/skip.
// Latency: 2 cycles per instruction (FETCH, EXEC), 3 for an enabled store (adds WRITE).
// Backpressure: halt freezes the sequencer in FETCH; EXEC and WRITE always run to completion.
module mc14500_icu
    import mc14500_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int PC_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            halt,
    output logic [PC_WIDTH-1:0]             prog_addr,
    input  logic [OPC_WIDTH+ADDR_WIDTH-1:0] prog_data,
    output logic [ADDR_WIDTH-1:0]           io_address,
    input  logic                            io_rd,
    output logic                            io_wr_data,
    output logic                            io_write,
    output logic                            rr,
    output logic                            jmp,
    output logic                            rtn,
    output logic                            flag_o,
    output logic                            flag_f
);

    state_t                          state;
    logic [PC_WIDTH-1:0]             pc;
    logic [OPC_WIDTH+ADDR_WIDTH-1:0] ir;
    logic                            ien;
    logic                            oen;
    logic                            skip;

    logic [OPC_WIDTH-1:0]            fetch_op;
    logic [OPC_WIDTH-1:0]            exec_op;
    logic [ADDR_WIDTH-1:0]           exec_operand;
    logic                            d;
    logic                            rr_next;

    assign fetch_op     = prog_data[OPC_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign exec_op      = ir[OPC_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
    assign exec_operand = ir[ADDR_WIDTH-1:0];
    assign d            = io_rd & ien;
    assign prog_addr    = pc;

    mc14500_lu u_lu (
        .op      (exec_op),
        .rr      (rr),
        .d       (d),
        .rr_next (rr_next)
    );

    // Sequencer FSM with all architectural registers, IO drive and strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_FETCH;
            pc         <= '0;
            ir         <= '0;
            rr         <= 1'b0;
            ien        <= 1'b0;
            oen        <= 1'b0;
            skip       <= 1'b0;
            io_address <= '0;
            io_wr_data <= 1'b0;
            io_write   <= 1'b0;
            jmp        <= 1'b0;
            rtn        <= 1'b0;
            flag_o     <= 1'b0;
            flag_f     <= 1'b0;
        end else begin
            // Strobes and the write pulse last exactly one cycle
            jmp      <= 1'b0;
            rtn      <= 1'b0;
            flag_o   <= 1'b0;
            flag_f   <= 1'b0;
            io_write <= 1'b0;

            case (state)
                ST_FETCH: begin
                    if (!halt) begin
                        ir         <= prog_data;
                        pc         <= pc + PC_WIDTH'(1);
                        // Address and store data are taken at fetch so they are
                        // already settled for the whole EXEC cycle, a full cycle
                        // ahead of the io_write rising edge.
                        io_address <= prog_data[ADDR_WIDTH-1:0];
                        if (opcode_t'(fetch_op) == OP_STO) begin
                            io_wr_data <= rr;
                        end else if (opcode_t'(fetch_op) == OP_STOC) begin
                            io_wr_data <= ~rr;
                        end
                        state      <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    state <= ST_FETCH;
                    if (skip) begin
                        // Skipped instruction: no state change, no strobes
                        skip <= 1'b0;
                    end else begin
                        rr <= rr_next;
                        case (opcode_t'(exec_op))
                            OP_NOPO: flag_o <= 1'b1;
                            OP_NOPF: flag_f <= 1'b1;
                            OP_STO, OP_STOC: begin
                                if (oen) begin
                                    io_write <= 1'b1;
                                    state    <= ST_WRITE;
                                end
                            end
                            OP_IEN: ien <= io_rd;
                            OP_OEN: oen <= io_rd;
                            OP_JMP: begin
                                pc  <= PC_WIDTH'(exec_operand);
                                jmp <= 1'b1;
                            end
                            OP_RTN: begin
                                skip <= 1'b1;
                                rtn  <= 1'b1;
                            end
                            OP_SKZ: skip <= ~rr;
                            default: ;
                        endcase
                    end
                end

                ST_WRITE: state <= ST_FETCH;

                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc14500_icu.sv
module tb_mc14500_icu;

    logic        clk;
    logic        reset;
    logic        halt;
    logic [7:0]  prog_addr;
    logic [10:0] prog_data;
    logic [6:0]  io_address;
    logic        io_rd;
    logic        io_wr_data;
    logic        io_write;
    logic        rr;
    logic        jmp;
    logic        rtn;
    logic        flag_o;
    logic        flag_f;

    logic [10:0]  mem [256];
    logic [127:0] io_vec;

    int          checks;
    int          passes;
    int          wr_count;
    logic [6:0]  last_addr;
    logic        last_data;

    mc14500_icu #(.ADDR_WIDTH(7), .PC_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .halt       (halt),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .io_address (io_address),
        .io_rd      (io_rd),
        .io_wr_data (io_wr_data),
        .io_write   (io_write),
        .rr         (rr),
        .jmp        (jmp),
        .rtn        (rtn),
        .flag_o     (flag_o),
        .flag_f     (flag_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign prog_data = mem[prog_addr];
    assign io_rd     = io_vec[io_address];

    // IO block model: captures each rising edge of io_write
    always @(posedge io_write) begin
        wr_count  = wr_count + 1;
        last_addr = io_address;
        last_data = io_wr_data;
    end

    function automatic logic [10:0] ins(input logic [3:0] op, input logic [6:0] a);
        return {op, a};
    endfunction

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset, clear program memory to the given filler opcode
    task automatic begin_prog(input logic [3:0] fill_op);
        reset = 1'b0;
        halt  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = ins(fill_op, 7'h00);
        @(negedge clk);
        wr_count = 0;
    endtask

    task automatic go();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        halt  = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = ins(4'hC, 7'h33);
        run(3);
        checks++; if (prog_addr !== 8'h00) $display("FAIL reset_pc: got %0h want 0", prog_addr); else passes++;
        checks++; if (rr !== 1'b0) $display("FAIL reset_rr: got %0b want 0", rr); else passes++;
        checks++; if (io_address !== 7'h00) $display("FAIL reset_addr: got %0h want 0", io_address); else passes++;
        checks++; if ({io_write, io_wr_data} !== 2'b00) $display("FAIL reset_io: got %b want 00", {io_write, io_wr_data}); else passes++;
        checks++; if ({jmp, rtn, flag_o, flag_f} !== 4'b0000) $display("FAIL reset_strobes: got %b want 0000", {jmp, rtn, flag_o, flag_f}); else passes++;
    endtask

    task automatic test_ld_ien();
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h05);
        mem[1] = ins(4'h1, 7'h05);
        go();
        run(1);
        checks++; if (io_address !== 7'h05) $display("FAIL ld_addr: got %0h want 5", io_address); else passes++;
        checks++; if (prog_addr !== 8'h01) $display("FAIL ld_pc1: got %0h want 1", prog_addr); else passes++;
        run(1);
        checks++; if (rr !== 1'b0) $display("FAIL ld_rr_after_ien: got %0b want 0", rr); else passes++;
        run(2);
        checks++; if (rr !== 1'b1) $display("FAIL ld_rr: got %0b want 1", rr); else passes++;
        checks++; if (prog_addr !== 8'h02) $display("FAIL ld_pc2: got %0h want 2", prog_addr); else passes++;
        checks++; if (wr_count !== 0) $display("FAIL ld_no_write: got %0d want 0", wr_count); else passes++;
    endtask

    task automatic test_logic();
        logic [6:0] exp_rr;
        exp_rr = 7'b0101010;
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h01);
        mem[1] = ins(4'h1, 7'h01);
        mem[2] = ins(4'h4, 7'h01);
        mem[3] = ins(4'h6, 7'h00);
        mem[4] = ins(4'h7, 7'h00);
        mem[5] = ins(4'h5, 7'h01);
        mem[6] = ins(4'h3, 7'h00);
        go();
        run(2);
        for (int i = 1; i <= 6; i++) begin
            run(2);
            checks++;
            if (rr !== exp_rr[i]) $display("FAIL logic_rr_%0d: got %0b want %0b", i, rr, exp_rr[i]);
            else passes++;
        end
        // With IEN=0 the data is masked to 0
        begin_prog(4'hF);
        mem[0] = ins(4'h1, 7'h01);
        mem[1] = ins(4'h2, 7'h01);
        go();
        run(2);
        checks++; if (rr !== 1'b0) $display("FAIL mask_ld: got %0b want 0", rr); else passes++;
        run(2);
        checks++; if (rr !== 1'b1) $display("FAIL mask_ldc: got %0b want 1", rr); else passes++;
    endtask

    task automatic load_store_prog();
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h01);
        mem[1] = ins(4'hB, 7'h01);
        mem[2] = ins(4'h1, 7'h01);
        mem[3] = ins(4'h9, 7'h42);
        mem[4] = ins(4'h8, 7'h43);
    endtask

    task automatic test_store();
        load_store_prog();
        go();
        run(7);
        checks++; if (io_address !== 7'h42) $display("FAIL stoc_addr: got %0h want 42", io_address); else passes++;
        checks++; if (io_wr_data !== 1'b0) $display("FAIL stoc_data: got %0b want 0", io_wr_data); else passes++;
        checks++; if (io_write !== 1'b0) $display("FAIL stoc_early_write: got %0b want 0", io_write); else passes++;
        run(1);
        checks++; if (io_write !== 1'b1) $display("FAIL stoc_write: got %0b want 1", io_write); else passes++;
        run(1);
        checks++; if (io_write !== 1'b0) $display("FAIL stoc_write_end: got %0b want 0", io_write); else passes++;
        checks++; if (io_address !== 7'h42) $display("FAIL stoc_addr_hold: got %0h want 42", io_address); else passes++;
        checks++; if ({wr_count, last_addr, last_data} !== {32'd1, 7'h42, 1'b0}) $display("FAIL stoc_io_seen: got %0d/%0h/%0b want 1/42/0", wr_count, last_addr, last_data); else passes++;
        run(1);
        checks++; if (prog_addr !== 8'h05) $display("FAIL stoc_3cyc: got %0h want 5", prog_addr); else passes++;
        checks++; if ({io_address, io_wr_data} !== {7'h43, 1'b1}) $display("FAIL sto_setup: got %0h/%0b want 43/1", io_address, io_wr_data); else passes++;
        run(2);
        checks++; if ({wr_count, last_addr, last_data} !== {32'd2, 7'h43, 1'b1}) $display("FAIL sto_io_seen: got %0d/%0h/%0b want 2/43/1", wr_count, last_addr, last_data); else passes++;
    endtask

    task automatic test_store_oen0();
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h01);
        mem[1] = ins(4'h1, 7'h01);
        mem[2] = ins(4'h8, 7'h42);
        go();
        run(6);
        checks++; if (io_write !== 1'b0) $display("FAIL oen0_write: got %0b want 0", io_write); else passes++;
        checks++; if (prog_addr !== 8'h03) $display("FAIL oen0_pc: got %0h want 3", prog_addr); else passes++;
        run(1);
        checks++; if (prog_addr !== 8'h04) $display("FAIL oen0_2cyc: got %0h want 4", prog_addr); else passes++;
        run(2);
        checks++; if (wr_count !== 0) $display("FAIL oen0_no_pulse: got %0d want 0", wr_count); else passes++;
    endtask

    task automatic test_skip();
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h01);
        mem[1] = ins(4'hE, 7'h00);
        mem[2] = ins(4'h2, 7'h00);
        go();
        run(6);
        checks++; if (rr !== 1'b0) $display("FAIL skz_taken: got %0b want 0", rr); else passes++;
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h01);
        mem[1] = ins(4'h1, 7'h01);
        mem[2] = ins(4'hE, 7'h00);
        mem[3] = ins(4'h2, 7'h00);
        go();
        run(8);
        checks++; if (rr !== 1'b1) $display("FAIL skz_not_taken_ldc: got %0b want 1", rr); else passes++;
        begin_prog(4'hF);
        mem[0] = ins(4'hA, 7'h01);
        mem[1] = ins(4'h1, 7'h01);
        mem[2] = ins(4'hE, 7'h00);
        mem[3] = ins(4'h1, 7'h00);
        go();
        run(8);
        checks++; if (rr !== 1'b0) $display("FAIL skz_not_taken_ld: got %0b want 0", rr); else passes++;
        // RTN skips the next instruction and its strobe
        begin_prog(4'hF);
        mem[0] = ins(4'hD, 7'h00);
        mem[1] = ins(4'h0, 7'h00);
        mem[2] = ins(4'h0, 7'h00);
        go();
        run(2);
        checks++; if (rtn !== 1'b1) $display("FAIL rtn_strobe: got %0b want 1", rtn); else passes++;
        run(2);
        checks++; if ({rtn, flag_o} !== 2'b00) $display("FAIL rtn_skip_strobe: got %b want 00", {rtn, flag_o}); else passes++;
        run(2);
        checks++; if (flag_o !== 1'b1) $display("FAIL nopo_strobe: got %0b want 1", flag_o); else passes++;
    endtask

    task automatic test_jmp_wrap();
        begin_prog(4'h0);
        mem[255] = ins(4'hC, 7'h10);
        go();
        run(2);
        checks++; if (flag_o !== 1'b1) $display("FAIL flag_o_on: got %0b want 1", flag_o); else passes++;
        run(1);
        checks++; if (flag_o !== 1'b0) $display("FAIL flag_o_off: got %0b want 0", flag_o); else passes++;
        run(508);
        checks++; if (prog_addr !== 8'h00) $display("FAIL jmp_pc_inc: got %0h want 0", prog_addr); else passes++;
        run(1);
        checks++; if ({jmp, prog_addr} !== {1'b1, 8'h10}) $display("FAIL jmp_target: got %b/%0h want 1/10", jmp, prog_addr); else passes++;
        begin_prog(4'hF);
        go();
        run(512);
        checks++; if ({jmp, flag_f, prog_addr} !== {2'b01, 8'h00}) $display("FAIL wrap: got %b%b/%0h want 01/0", jmp, flag_f, prog_addr); else passes++;
        run(1);
        checks++; if (prog_addr !== 8'h01) $display("FAIL wrap_next: got %0h want 1", prog_addr); else passes++;
    endtask

    task automatic test_reset_mid_write();
        load_store_prog();
        go();
        run(8);
        checks++; if ({io_write, rr} !== 2'b11) $display("FAIL mid_pre: got %b want 11", {io_write, rr}); else passes++;
        reset = 1'b0;
        #1;
        checks++; if ({io_write, rr, prog_addr} !== {2'b00, 8'h00}) $display("FAIL mid_reset: got %b%b/%0h want 00/0", io_write, rr, prog_addr); else passes++;
        @(negedge clk);
        reset = 1'b1;
        run(1);
        checks++; if (prog_addr !== 8'h01) $display("FAIL mid_restart: got %0h want 1", prog_addr); else passes++;
        checks++; if (wr_count !== 1) $display("FAIL mid_edges: got %0d want 1", wr_count); else passes++;
    endtask

    task automatic test_halt();
        begin_prog(4'hF);
        halt = 1'b1;
        go();
        run(20);
        checks++; if (prog_addr !== 8'h00) $display("FAIL halt_hold: got %0h want 0", prog_addr); else passes++;
        halt = 1'b0;
        run(1);
        checks++; if (prog_addr !== 8'h01) $display("FAIL halt_release: got %0h want 1", prog_addr); else passes++;
        halt = 1'b1;
        run(1);
        checks++; if (flag_f !== 1'b1) $display("FAIL halt_exec_done: got %0b want 1", flag_f); else passes++;
        run(10);
        checks++; if (prog_addr !== 8'h01) $display("FAIL halt_hold2: got %0h want 1", prog_addr); else passes++;
        halt = 1'b0;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        wr_count  = 0;
        last_addr = '0;
        last_data = 1'b0;
        io_vec    = '0;
        io_vec[1] = 1'b1;
        io_vec[5] = 1'b1;
        reset     = 1'b0;
        halt      = 1'b0;

        test_reset();
        test_ld_ien();
        test_logic();
        test_store();
        test_store_oen0();
        test_skip();
        test_jmp_wrap();
        test_reset_mid_write();
        test_halt();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
